// File: rtl/debug_dump_unit_pkg.sv
// Shared types and constants for the architectural-state dump engine.
// Stream tags are {kind[1:0], index[5:0]}.
package debug_dump_unit_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_REGS,
    S_MEM,
    S_DONE
  } state_e;

  localparam logic [1:0] TAG_HDR = 2'd0;
  localparam logic [1:0] TAG_REG = 2'd1;
  localparam logic [1:0] TAG_MEM = 2'd2;

  localparam int HDR_WORDS = 4;
  localparam int IDX_W     = 6;

endpackage

// File: rtl/debug_dump_unit_sat_counter.sv
// Enabled up-counter that sticks at all-ones instead of wrapping.
// Used for the run/stall/flush cycle statistics.
module dbg_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/debug_dump_unit.sv
// Architectural-state dump engine: header (counters, PC), GPRs, then
// the first DMEM words, streamed one word per cycle over valid/ready.
module debug_dump_unit
  import debug_dump_unit_pkg::*;
#(
  parameter  int NUM_REGS   = 32,
  parameter  int DMEM_WORDS = 8,
  parameter  int CNT_W      = 32,
  localparam int REG_AW     = $clog2(NUM_REGS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [31:0]       pc_i,
  input  logic              dump_req_i,
  output logic [REG_AW-1:0] reg_addr_o,
  input  logic [31:0]       reg_data_i,
  output logic [31:0]       mem_addr_o,
  input  logic [31:0]       mem_data_i,
  output logic              dump_valid_o,
  output logic [31:0]       dump_data_o,
  output logic [7:0]        dump_tag_o,
  input  logic              dump_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  cycle_cnt_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      snap_cyc_q, snap_stl_q, snap_fls_q, snap_pc_q;
  logic             valid_q, busy_q, done_q;
  logic [31:0]      data_q;
  logic [7:0]       tag_q;

  logic             producing, sec_last, load;
  logic [31:0]      word_d;
  logic [7:0]       tag_d;
  state_e           sec_next;

  dbg_sat_counter #(.W(CNT_W)) u_cyc (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (start_i),
    .cnt_o (cycle_cnt_o)
  );

  dbg_sat_counter #(.W(CNT_W)) u_stl (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (start_i & stall_i),
    .cnt_o (stall_cnt_o)
  );

  dbg_sat_counter #(.W(CNT_W)) u_fls (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (start_i & flush_i),
    .cnt_o (flush_cnt_o)
  );

  always_comb begin
    producing = 1'b0;
    sec_last  = 1'b0;
    word_d    = '0;
    tag_d     = '0;
    sec_next  = state_q;
    unique case (1'b1)
      (state_q == S_HDR): begin
        producing = 1'b1;
        sec_last  = (idx_q == IDX_W'(HDR_WORDS - 1));
        tag_d     = {TAG_HDR, idx_q};
        sec_next  = S_REGS;
        unique case (idx_q[1:0])
          2'd0: word_d = snap_cyc_q;
          2'd1: word_d = snap_stl_q;
          2'd2: word_d = snap_fls_q;
          2'd3: word_d = snap_pc_q;
        endcase
      end
      (state_q == S_REGS): begin
        producing = 1'b1;
        sec_last  = (idx_q == IDX_W'(NUM_REGS - 1));
        tag_d     = {TAG_REG, idx_q};
        word_d    = reg_data_i;
        sec_next  = S_MEM;
      end
      (state_q == S_MEM): begin
        // idx past the end means all words are loaded; just drain
        producing = (idx_q < IDX_W'(DMEM_WORDS));
        sec_last  = (idx_q == IDX_W'(DMEM_WORDS - 1));
        tag_d     = {TAG_MEM, idx_q};
        word_d    = mem_data_i;
        sec_next  = S_MEM;
      end
      default: ;
    endcase
  end

  assign load = producing && (!valid_q || dump_ready_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      snap_cyc_q <= '0;
      snap_stl_q <= '0;
      snap_fls_q <= '0;
      snap_pc_q  <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      tag_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (dump_req_i) begin
            snap_cyc_q <= 32'(cycle_cnt_o);
            snap_stl_q <= 32'(stall_cnt_o);
            snap_fls_q <= 32'(flush_cnt_o);
            snap_pc_q  <= pc_i;
            idx_q      <= '0;
            busy_q     <= 1'b1;
            state_q    <= S_HDR;
          end
        end
        S_HDR, S_REGS, S_MEM: begin
          if (load) begin
            valid_q <= 1'b1;
            data_q  <= word_d;
            tag_q   <= tag_d;
            if (sec_last && (state_q != S_MEM)) idx_q <= '0;
            else idx_q <= idx_q + IDX_W'(1);
            if (sec_last) state_q <= sec_next;
          end else if (valid_q && dump_ready_i) begin
            valid_q <= 1'b0;
            if (!producing) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign reg_addr_o   = (state_q == S_REGS) ? idx_q[REG_AW-1:0] : '0;
  assign mem_addr_o   = (state_q == S_MEM && producing) ?
                        32'({idx_q, 2'b00}) : '0;
  assign dump_valid_o = valid_q;
  assign dump_data_o  = data_q;
  assign dump_tag_o   = tag_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_debug_dump_unit.sv
// Directed bench for debug_dump_unit with a scoreboard of expected
// stream words and a handshake monitor on the falling clock edge.
module tb_debug_dump_unit;

  localparam int NR = 32;
  localparam int ND = 8;

  typedef struct packed {
    logic [7:0]  tag;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, stall, flush, req, ready;
  logic [31:0] pc;
  logic [4:0]  reg_addr;
  logic [31:0] reg_data, mem_addr, mem_data;
  logic        valid, busy, done;
  logic [31:0] data;
  logic [7:0]  tag;
  logic [31:0] ccnt, scnt, fcnt;

  logic        start2, stall2;
  logic [4:0]  s_ra;
  logic [31:0] s_ma, s_d;
  logic        s_v, s_b, s_dn;
  logic [7:0]  s_t;
  logic [3:0]  s_c, s_s, s_f;

  logic [31:0] regs [NR];
  logic [31:0] dmem [ND];
  exp_t        sb [$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign reg_data = regs[reg_addr];
  assign mem_data = dmem[mem_addr[4:2]];

  debug_dump_unit #(.NUM_REGS(NR), .DMEM_WORDS(ND), .CNT_W(32)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .stall_i      (stall),
    .flush_i      (flush),
    .pc_i         (pc),
    .dump_req_i   (req),
    .reg_addr_o   (reg_addr),
    .reg_data_i   (reg_data),
    .mem_addr_o   (mem_addr),
    .mem_data_i   (mem_data),
    .dump_valid_o (valid),
    .dump_data_o  (data),
    .dump_tag_o   (tag),
    .dump_ready_i (ready),
    .busy_o       (busy),
    .done_o       (done),
    .cycle_cnt_o  (ccnt),
    .stall_cnt_o  (scnt),
    .flush_cnt_o  (fcnt)
  );

  debug_dump_unit #(.NUM_REGS(NR), .DMEM_WORDS(ND), .CNT_W(4)) u_sat (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start2),
    .stall_i      (stall2),
    .flush_i      (1'b0),
    .pc_i         (32'h0),
    .dump_req_i   (1'b0),
    .reg_addr_o   (s_ra),
    .reg_data_i   (32'h0),
    .mem_addr_o   (s_ma),
    .mem_data_i   (32'h0),
    .dump_valid_o (s_v),
    .dump_data_o  (s_d),
    .dump_tag_o   (s_t),
    .dump_ready_i (1'b1),
    .busy_o       (s_b),
    .done_o       (s_dn),
    .cycle_cnt_o  (s_c),
    .stall_cnt_o  (s_s),
    .flush_cnt_o  (s_f)
  );

  task automatic check(input string name, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_dump(input logic [31:0] c, input logic [31:0] s,
                           input logic [31:0] f, input logic [31:0] p);
    exp_t e;
    e.tag = 8'h00; e.data = c; sb.push_back(e);
    e.tag = 8'h01; e.data = s; sb.push_back(e);
    e.tag = 8'h02; e.data = f; sb.push_back(e);
    e.tag = 8'h03; e.data = p; sb.push_back(e);
    for (int i = 0; i < NR; i++) begin
      e.tag = {2'd1, 6'(i)}; e.data = regs[i]; sb.push_back(e);
    end
    for (int i = 0; i < ND; i++) begin
      e.tag = {2'd2, 6'(i)}; e.data = dmem[i]; sb.push_back(e);
    end
  endtask

  task automatic wait_done(input int lim, input bit rnd, output int at);
    int k = 0;
    while (!done && k < lim) begin
      if (rnd) ready = 1'($urandom_range(0, 1));
      tick();
      k++;
    end
    check("done_timeout", {31'd0, done}, 32'd1);
    at = cyc;
  endtask

  // Handshake monitor: words accepted at the next rising edge
  logic        hold_pend = 1'b0;
  logic [31:0] hold_data;
  logic [7:0]  hold_tag;
  always @(negedge clk) begin
    exp_t e;
    if (done) done_cnt++;
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        check("hold_valid", {31'd0, valid}, 32'd1);
        check("hold_data", data, hold_data);
        check("hold_tag", {24'd0, tag}, {24'd0, hold_tag});
      end
      if (valid && ready) begin
        check("unexpected_word", {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("word_tag", {24'd0, tag}, {24'd0, e.tag});
          check("word_data", data, e.data);
        end
      end
      hold_pend = valid && !ready;
      hold_data = data;
      hold_tag  = tag;
    end
  end

  initial begin
    int n0, t, d0;
    rst = 1'b1; start = 0; stall = 0; flush = 0; req = 0; ready = 0;
    pc = 32'h0; start2 = 0; stall2 = 0;
    for (int i = 0; i < NR; i++) regs[i] = 32'hA000_0000 + i;
    for (int i = 0; i < ND; i++) dmem[i] = 32'hB000_0000 + i;
    regs[8] = 32'd5;
    dmem[0] = 32'd5;
    #2;
    check("rst_cycle", ccnt, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    repeat (2) tick();
    rst = 1'b0;

    // counters: 20 running cycles, 3 stalls, 2 flushes
    start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      stall = (i == 2 || i == 5 || i == 11);
      flush = (i == 7 || i == 8);
      tick();
    end
    start = 1'b0; stall = 1'b1; flush = 1'b1;
    repeat (2) tick();
    stall = 1'b0; flush = 1'b0;
    check("cnt_cycle", ccnt, 32'd20);
    check("cnt_stall", scnt, 32'd3);
    check("cnt_flush", fcnt, 32'd2);

    // full-rate dump with latency check
    ready = 1'b1;
    pc = 32'h0000_0100;
    push_dump(32'd20, 32'd3, 32'd2, pc);
    req = 1'b1;
    tick();
    req = 1'b0;
    n0 = cyc;
    pc = 32'h0000_0DEA;
    check("busy_after_req", {31'd0, busy}, 32'd1);
    tick();
    check("word0_latency", {31'd0, valid}, 32'd1);
    wait_done(200, 1'b0, t);
    check("done_cycle", 32'(t - n0), 32'd45);
    check("done_busy", {31'd0, busy}, 32'd0);
    check("done_valid", {31'd0, valid}, 32'd0);
    check("sb_empty_full", 32'(sb.size()), 32'd0);
    tick();
    check("done_pulse", {31'd0, done}, 32'd0);

    // random backpressure
    pc = 32'h0000_0200;
    push_dump(32'd20, 32'd3, 32'd2, pc);
    req = 1'b1;
    tick();
    req = 1'b0;
    wait_done(600, 1'b1, t);
    ready = 1'b1;
    check("sb_empty_rand", 32'(sb.size()), 32'd0);
    tick();

    // request held high: one dump per IDLE entry
    d0 = done_cnt;
    pc = 32'h0000_0300;
    push_dump(32'd20, 32'd3, 32'd2, pc);
    req = 1'b1;
    tick();
    wait_done(200, 1'b0, t);
    check("held_sb_empty", 32'(sb.size()), 32'd0);
    push_dump(32'd20, 32'd3, 32'd2, pc);
    tick();
    check("held_no_restart_in_done", {31'd0, busy}, 32'd0);
    tick();
    check("held_restart_in_idle", {31'd0, busy}, 32'd1);
    req = 1'b0;
    wait_done(200, 1'b0, t);
    tick();
    check("held_done_pulses", 32'(done_cnt - d0), 32'd2);
    check("held_sb_empty2", 32'(sb.size()), 32'd0);

    // asynchronous reset mid-dump
    pc = 32'h0000_0400;
    push_dump(32'd20, 32'd3, 32'd2, pc);
    req = 1'b1;
    tick();
    req = 1'b0;
    repeat (10) tick();
    #2 rst = 1'b1;
    #1;
    check("arst_valid", {31'd0, valid}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_cycle", ccnt, 32'd0);
    check("arst_stall", scnt, 32'd0);
    check("arst_flush", fcnt, 32'd0);
    sb.delete();
    d0 = done_cnt;
    tick();
    rst = 1'b0;
    repeat (5) tick();
    check("arst_no_done", 32'(done_cnt), 32'(d0));
    check("arst_idle_valid", {31'd0, valid}, 32'd0);

    // saturation on a 4-bit counter instance
    start2 = 1'b1; stall2 = 1'b1;
    repeat (14) tick();
    check("sat_pre_cycle", {28'd0, s_c}, 32'd14);
    check("sat_pre_stall", {28'd0, s_s}, 32'd14);
    repeat (3) tick();
    check("sat_cycle", {28'd0, s_c}, 32'd15);
    check("sat_stall", {28'd0, s_s}, 32'd15);
    check("sat_flush", {28'd0, s_f}, 32'd0);
    start2 = 1'b0; stall2 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
